serial_sub2: RTL and testbench
==============================

Name: serial_sub2

Overview:
- Multi-cycle bit-serial subtractor; the inverse-direction companion of the team's 2-bit ripple adder slice (carry in, 2-bit sum, carry out).
- Recovers a WIDTH-bit difference two bits per clock using one 2-bit borrow slice.
- Operands arrive and results leave on valid/ready handshakes.
- Sits between operand producers and consumers in the arithmetic benchmark datapaths.

Parameters:
- WIDTH, 8, operand/result width in bits; must be even and >= 2, otherwise elaboration error.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand set valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- bin  input  1  borrow in
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- diff  output  WIDTH  (a - b - bin) mod 2^WIDTH
- bout  output  1  borrow out; 1 iff a < b + bin (unsigned)

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: in_ready=0 while rst asserted and 1 in the first cycle after release; out_valid=0, diff=0, bout=0. All shift registers, counter and borrow flop are cleared.
- FSM states:
  - IDLE: in_ready=1, out_valid=0. in_valid&in_ready captures a, b into shift registers and bin into the borrow flop, loads count=WIDTH/2-1, then goes to RUN.
  - RUN: in_ready=0. Each cycle, sub2_slice takes the low 2 bits of a_sh and b_sh plus the borrow flop.
    - Shift a_sh and b_sh right by 2.
    - Shift the 2 slice difference bits into the top of d_sh.
    - Borrow flop <= slice borrow out.
    - When count==0, go to DONE; otherwise count decrements.
  - DONE: out_valid=1; diff=d_sh and bout=borrow flop, both stable until the handshake. out_valid&out_ready returns to IDLE. out_valid must never drop without out_ready.
- Latency: the accept edge is cycle 0. RUN occupies cycles 1..WIDTH/2. out_valid rises in cycle WIDTH/2+1; for WIDTH=8, that is 5 cycles.
- Throughput: one operation per WIDTH/2+2 cycles, minimum. There is no IDLE bypass, so in_ready is low during RUN and DONE.
- in_valid outside IDLE is ignored; operands are not captured.
- Slice arithmetic per 2 bits:
  - {bo, d1, d0} = {a1,a0} - {b1,b0} - bi, computed 3-bit wide.
  - bo is the inverted carry of a + ~b + ~bi.
- Boundaries:
  - a==b with bin=0 gives diff=0, bout=0.
  - All-zero minus nonzero wraps to 2^WIDTH-(b+bin) with bout=1.
  - b=2^WIDTH-1 with bin=1 gives diff=a, bout=1.
- Reset mid-operation: asserting rst in RUN or DONE aborts asynchronously. The in-flight result is lost, with no partial output.
- out_ready held high during RUN has no effect.

Decomposition:
- Package serial_sub2_pkg holds:
  - state enum {IDLE, RUN, DONE}, 2 bits;
  - localparam SLICE_W=2;
  - function num_slices(WIDTH)=WIDTH/SLICE_W;
  - counter width, $clog2(WIDTH/2) with a minimum of 1.
- Sub-module sub2_slice: purely combinational. Inputs a[1:0], b[1:0], bi; outputs d[1:0], bo.
- Unit-test sub2_slice exhaustively over all 32 input vectors.

Test Plan (WIDTH=8):
- Basic subtraction: a=0x5A, b=0x23, bin=0, out_ready=1 → out_valid in cycle 5; diff=0x37, bout=0. One-cycle out_valid pulse, then in_ready=1.
- Wrap-around: a=0x00, b=0x01, bin=0 → diff=0xFF, bout=1. Also a=0xFF, b=0xFF, bin=1 → diff=0xFF, bout=1.
- Backpressure: a=0x80, b=0x01, bin=1, out_ready=0 for 6 cycles after out_valid → diff=0x7E and bout=0 held stable with out_valid=1 and in_ready=0. Releasing out_ready completes in 1 cycle.
- Ignored input: in_valid held with new operands during RUN → in_ready=0, operands not captured, result reflects the first operand set only.
- Reset mid-run: rst pulsed in RUN cycle 2 → out_valid=0, diff=0, bout=0 immediately. in_ready=1 in the first cycle after release. A following a=0x10, b=0x10 yields diff=0x00, bout=0.
- Randomized back-to-back: 1000 random transactions with random valid/ready stalls, checked against the reference model (a-b-bin) mod 256, with bout from the 9-bit result.

Source files
------------

// File: rtl/serial_sub2_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
`timescale 1ns/1ps

package serial_sub2_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SLICE_W = 2;

  function automatic int num_slices(input int width);
    return width / SLICE_W;
  endfunction

  function automatic int cnt_width(input int width);
    int w;
    w = $clog2(width / SLICE_W);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/serial_sub2_slice.sv
// Combinational 2-bit borrow slice: {bo, d} = a - b - bi.
`timescale 1ns/1ps

module sub2_slice
  import serial_sub2_pkg::*;
(
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       bi,
  output logic [1:0] d,
  output logic       bo
);

  logic [2:0] w_full;

  // A 3-bit wide subtract leaves the borrow in the top bit as two's complement sign.
  always_comb begin
    w_full = {1'b0, a} - {1'b0, b} - {2'b00, bi};
    d      = w_full[1:0];
    bo     = w_full[2];
  end

endmodule

// File: rtl/serial_sub2.sv
// Bit-serial subtractor: WIDTH-bit a - b - bin, two bits per clock.
`timescale 1ns/1ps

module serial_sub2
  import serial_sub2_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int NSLICE = num_slices(WIDTH);
  localparam int CNT_W  = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(NSLICE - 1);

  generate
    if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_badWidth
      $error("serial_sub2: WIDTH must be even and >= 2");
    end
  endgenerate

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_aSh;
  logic [WIDTH-1:0] r_bSh;
  logic [WIDTH-1:0] r_dSh;
  logic             r_borrow;
  logic [CNT_W-1:0] r_count;
  logic [1:0]       w_sliceD;
  logic             w_sliceBo;
  logic             w_accept;

  sub2_slice u_slice (
    .a  (r_aSh[1:0]),
    .b  (r_bSh[1:0]),
    .bi (r_borrow),
    .d  (w_sliceD),
    .bo (w_sliceBo)
  );

  // Ready is masked by reset so nothing is accepted while reset is held.
  assign in_ready  = (r_state == IDLE) && !rst;
  assign out_valid = (r_state == DONE);
  assign w_accept  = in_valid && in_ready;
  assign diff      = out_valid ? r_dSh : '0;
  assign bout      = out_valid && r_borrow;

  // State register, cleared asynchronously so an in-flight result is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: accept in IDLE, count down slices in RUN, hold in DONE until taken.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_nextState = RUN;
      RUN:     if (r_count == '0) w_nextState = DONE;
      DONE:    if (out_ready) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Datapath: load operands on accept, then consume two bits per RUN cycle LSB first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_aSh    <= '0;
      r_bSh    <= '0;
      r_dSh    <= '0;
      r_borrow <= 1'b0;
      r_count  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_aSh    <= a;
            r_bSh    <= b;
            r_dSh    <= '0;
            r_borrow <= bin;
            r_count  <= CNT_LOAD;
          end
        end
        RUN: begin
          r_aSh    <= r_aSh >> SLICE_W;
          r_bSh    <= r_bSh >> SLICE_W;
          r_dSh    <= (r_dSh >> SLICE_W) | (WIDTH'(w_sliceD) << (WIDTH - SLICE_W));
          r_borrow <= w_sliceBo;
          if (r_count != '0) begin
            r_count <= r_count - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub2.sv
// Self-checking bench for serial_sub2 (WIDTH=8) and its 2-bit borrow slice.
`timescale 1ns/1ps

module tb_serial_sub2;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;

  logic [1:0] sa;
  logic [1:0] sb;
  logic       sbi;
  logic [1:0] sd;
  logic       sbo;

  int testCount;
  int failCount;

  serial_sub2 #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout)
  );

  sub2_slice u_sliceDut (
    .a  (sa),
    .b  (sb),
    .bi (sbi),
    .d  (sd),
    .bo (sbo)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #2ms;
    $display("[TB] FAIL globalTimeout: simulation did not finish, required finish before 2ms");
    $fatal(1, "[TB] global timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One full transaction: optional idle gap, offer operands, check RUN timing,
  // check the result against plain integer arithmetic, then hold off out_ready
  // for `stalls` cycles (negative means random stalls) and complete the handshake.
  task automatic applyStimulus(input logic [7:0] ta, input logic [7:0] tbv, input logic tbin,
                               input int gap, input int stalls, input bit holdValid,
                               input bit preReady);
    int guard;
    int lat;
    int r;
    int stalled;
    logic [7:0] expDiff;
    logic expBout;
    logic readyNow;
    r = int'(ta) - int'(tbv) - int'(tbin);
    expDiff = 8'(r & 255);
    expBout = (r < 0);
    out_ready = preReady;
    repeat (gap) @(negedge clk);
    a = ta;
    b = tbv;
    bin = tbin;
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("inReadyIdle", 32'(in_ready), 32'd1);
    @(negedge clk);
    if (holdValid) begin
      a = 8'($urandom);
      b = 8'($urandom);
      bin = 1'($urandom);
    end else begin
      in_valid = 1'b0;
    end
    lat = 0;
    while (!out_valid && lat < 40) begin
      checkOutput("inReadyBusy", 32'(in_ready), 32'd0);
      @(negedge clk);
      if (holdValid) begin
        a = 8'($urandom);
        b = 8'($urandom);
        bin = 1'($urandom);
      end
      lat++;
    end
    in_valid = 1'b0;
    checkOutput("latency", 32'(lat), 32'(WIDTH / 2));
    checkOutput("diff", 32'(diff), 32'(expDiff));
    checkOutput("bout", 32'(bout), 32'(expBout));
    checkOutput("inReadyDone", 32'(in_ready), 32'd0);
    stalled = 0;
    do begin
      if (stalls < 0) begin
        readyNow = ($urandom_range(0, 2) != 0) || (stalled >= 5);
      end else begin
        readyNow = (stalled >= stalls);
      end
      out_ready = readyNow;
      @(negedge clk);
      if (!readyNow) begin
        stalled++;
        checkOutput("holdValid", 32'(out_valid), 32'd1);
        checkOutput("holdDiff", 32'(diff), 32'(expDiff));
        checkOutput("holdBout", 32'(bout), 32'(expBout));
        checkOutput("holdInReady", 32'(in_ready), 32'd0);
      end
    end while (!readyNow);
    checkOutput("validDrop", 32'(out_valid), 32'd0);
    checkOutput("inReadyBack", 32'(in_ready), 32'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    int r;
    int guard;
    testCount = 0;
    failCount = 0;
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    bin = 1'b0;
    sa = '0;
    sb = '0;
    sbi = 1'b0;

    // Exhaustive check of the 2-bit slice.
    for (int v = 0; v < 32; v++) begin
      {sa, sb, sbi} = 5'(v);
      #1;
      r = int'(sa) - int'(sb) - int'(sbi);
      checkOutput("sliceD", 32'(sd), 32'(r & 3));
      checkOutput("sliceBo", 32'(sbo), (r < 0) ? 32'd1 : 32'd0);
    end

    // Reset state.
    #2 rst = 1'b1;
    #2;
    checkOutput("rstInReady", 32'(in_ready), 32'd0);
    checkOutput("rstOutValid", 32'(out_valid), 32'd0);
    checkOutput("rstDiff", 32'(diff), 32'd0);
    checkOutput("rstBout", 32'(bout), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("relInReady", 32'(in_ready), 32'd1);
    @(negedge clk);

    // Directed cases.
    applyStimulus(8'h5A, 8'h23, 1'b0, 0, 0, 1'b0, 1'b1);
    applyStimulus(8'h00, 8'h01, 1'b0, 0, 0, 1'b0, 1'b1);
    applyStimulus(8'hFF, 8'hFF, 1'b1, 0, 0, 1'b0, 1'b1);
    applyStimulus(8'h80, 8'h01, 1'b1, 0, 6, 1'b0, 1'b0);
    applyStimulus(8'h3C, 8'h3C, 1'b0, 1, 0, 1'b0, 1'b0);
    applyStimulus(8'h5D, 8'hFF, 1'b1, 0, 2, 1'b0, 1'b1);
    applyStimulus(8'h12, 8'h34, 1'b0, 0, 1, 1'b1, 1'b1);

    // Reset during RUN.
    a = 8'h77;
    b = 8'h22;
    bin = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("runRstValid", 32'(out_valid), 32'd0);
    checkOutput("runRstDiff", 32'(diff), 32'd0);
    checkOutput("runRstBout", 32'(bout), 32'd0);
    checkOutput("runRstInReady", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("runRelInReady", 32'(in_ready), 32'd1);
    applyStimulus(8'h10, 8'h10, 1'b0, 1, 0, 1'b0, 1'b0);

    // Reset while a result is waiting in DONE.
    a = 8'hAA;
    b = 8'h11;
    bin = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("doneReached", 32'(out_valid), 32'd1);
    checkOutput("doneDiff", 32'(diff), 32'h99);
    rst = 1'b1;
    #1;
    checkOutput("doneRstValid", 32'(out_valid), 32'd0);
    checkOutput("doneRstDiff", 32'(diff), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("doneRelInReady", 32'(in_ready), 32'd1);
    @(negedge clk);

    // Randomized transactions with random gaps and output stalls.
    for (int t = 0; t < 1000; t++) begin
      applyStimulus(8'($urandom), 8'($urandom), 1'($urandom),
                    int'($urandom_range(0, 2)), -1, 1'b0, 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
